// File: rtl/risc_prog_loader_if.sv
// Byte-stream handshake bundle feeding the program loader.
// Signals: in_data (byte), in_valid (source), in_ready (loader).
interface risc_prog_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/risc_prog_loader.sv
// Boot loader: assembles a byte stream into 16-bit words and writes them
// to instruction memory, holding the core in reset until the image is in.
// Ports: clk, rst (sync, active high), in_if (byte stream, slave),
//   reload (restart from RUN/ERR), mem_we/mem_addr/mem_wdata (imem write),
//   cpu_rst (core reset), done (core running), err (count > DEPTH).
module risc_prog_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    risc_prog_loader_if.slave   in_if,
    input  logic                reload,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                cpu_rst,
    output logic                done,
    output logic                err
);

    localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DAT_HI,
        DAT_LO,
        RUN,
        ERR
    } state_t;

    state_t state, state_nxt;

    logic              xfer;
    logic [7:0]        cnt_hi;
    logic [7:0]        dat_hi;
    logic [15:0]       remain;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       cnt_w;

    assign xfer  = in_if.in_valid && in_if.in_ready;
    assign cnt_w = {cnt_hi, in_if.in_data};

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= HDR_HI;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            HDR_HI: if (xfer) state_nxt = HDR_LO;
            HDR_LO: begin
                if (xfer) begin
                    if (cnt_w == 16'd0)
                        state_nxt = RUN;
                    else if ({1'b0, cnt_w} > DEPTH)
                        state_nxt = ERR;
                    else
                        state_nxt = DAT_HI;
                end
            end
            DAT_HI: if (xfer) state_nxt = DAT_LO;
            DAT_LO: begin
                if (xfer)
                    state_nxt = (remain == 16'd1) ? RUN : DAT_HI;
            end
            RUN:     if (reload) state_nxt = HDR_HI;
            ERR:     if (reload) state_nxt = HDR_HI;
            default: state_nxt = HDR_HI;
        endcase
    end

    // Outputs. The final word is still being strobed during the first
    // RUN cycle, so done/cpu_rst wait for that strobe to retire.
    always_comb begin
        in_if.in_ready = (state == HDR_HI) || (state == HDR_LO) ||
                         (state == DAT_HI) || (state == DAT_LO);
        done           = (state == RUN) && !mem_we;
        cpu_rst        = !done;
        err            = (state == ERR);
    end

    // Datapath: header/word capture and registered memory write
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_hi    <= '0;
            dat_hi    <= '0;
            remain    <= '0;
            addr      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (xfer && state == HDR_HI)
                cnt_hi <= in_if.in_data;
            if (xfer && state == HDR_LO) begin
                remain <= cnt_w;
                addr   <= '0;
            end
            if (xfer && state == DAT_HI)
                dat_hi <= in_if.in_data;
            if (xfer && state == DAT_LO) begin
                mem_we    <= 1'b1;
                mem_addr  <= addr;
                mem_wdata <= DATA_W'({dat_hi, in_if.in_data});
                addr      <= addr + 1'b1;
                remain    <= remain - 16'd1;
            end
        end
    end

endmodule
